dpram_mp: RTL
=============

Name: dpram_mp

Overview:
- Parametrised successor to the team's 8x64 true dual-port RAM: two independent read/write ports share one storage array.
- Adds configurable width, depth and read latency, per-port read-valid flags, same-address collision detection with programmable write priority, and a selectable read-during-write mode.
- After reset, a hardware sweep zeroes the whole array.
- Used as a scratch/buffer memory between two masters in the same clock domain.

Parameters:
- DATA_W, 8, word width in bits.
- DEPTH, 64, number of words; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- WR_PRIO, 0, port that wins a same-address double write (0 or 1).
- RDW_NEW, 0, same-address write+read across ports: 0 = read returns old data, 1 = read returns new data (write-through).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; 0 = outputs cleared, no access.
- wr0  input  1  port 0 mode: 0 = write, 1 = read.
- wr1  input  1  port 1 mode: 0 = write, 1 = read.
- add0  input  ADDR_W  port 0 address.
- add1  input  ADDR_W  port 1 address.
- data0_in  input  DATA_W  port 0 write data.
- data1_in  input  DATA_W  port 1 write data.
- data0_out  output  DATA_W  port 0 read data.
- data1_out  output  DATA_W  port 1 read data.
- valid0  output  1  data0_out holds fresh read data this cycle.
- valid1  output  1  data1_out holds fresh read data this cycle.
- collision  output  1  one-cycle pulse: both ports wrote the same address.
- init_busy  output  1  clear sweep in progress; ports ignored.

Behaviour:
- Reset (rst=1 at posedge):
  - data*_out=0, valid*=0, collision=0, all pipeline stages=0.
  - Sweep FSM enters CLEAR with clr_addr=0.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- FSM states CLEAR -> RUN:
  - CLEAR: init_busy=1. Each cycle writes 0 to mem[clr_addr] and increments clr_addr. Port inputs and en are ignored and valid*=0.
  - On clr_addr==DEPTH-1, go to RUN. Sweep lasts exactly DEPTH cycles after rst deasserts.
  - RUN: init_busy=0. Stays in RUN until rst.
- en=0 in RUN: at next edge data*_out=0, valid*=0, collision=0, no memory write, pipeline stages flushed to 0.
- Write: wrN=0 and en=1 stores dataN_in at addN at the edge. validN=0 for that access.
- Read: wrN=1 and en=1.
  - READ_LAT=1: mem[addN] is in dataN_out with validN=1 after the next edge.
  - READ_LAT=2: one extra registered stage, so data and valid appear one cycle later.
  - When no read is in flight, dataN_out holds its last value and validN=0.
- Double write to the same address (wr0=wr1=0, add0==add1):
  - Only port WR_PRIO's data is stored.
  - collision=1 for exactly one cycle, aligned with the write edge (registered, visible the cycle after).
- Write on one port, read on the other, same address:
  - RDW_NEW=0: the read returns the pre-write contents.
  - RDW_NEW=1: the read returns the write data (bypass mux).
  - No collision flag.
- Both ports read the same address: both return the same data; no collision.
- Different addresses: fully independent, one access per port per cycle.
- Address arithmetic: addresses are ADDR_W wide, so there is no out-of-range access. clr_addr is ADDR_W+1 bits or stops at DEPTH-1 (no wrap past end).

Optional Feature:
- Macro DPRAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed on write; the sweep writes parity 0.
  - Outputs parity_err0 and parity_err1 (1 bit each) are added. Each is aligned with its validN and is 1 when the stored parity mismatches the read data.
  - Both outputs reset to 0.
- Undefined: no parity storage and no parity_err ports; the array is DATA_W bits wide.

Decomposition:
- Package dpram_pkg:
  - State enum sweep_state_t {CLEAR, RUN}.
  - Constants for the RDW_NEW encoding.
  - Function even_parity(DATA_W-bit word).
- One natural sub-module: dpram_rd_pipe, the per-port READ_LAT stage (data plus valid plus parity_err). Instantiated twice.

Test Plan:
- Reset then wait: rst=1 for 2 cycles, then 0 -> init_busy=1 for exactly 64 cycles; reading address 0x3F afterwards gives 0x00 with valid1=1.
- Basic write/read: port0 writes 0xA5 to addr 0x10; next cycle port1 reads 0x10 -> data1_out=0xA5, valid1=1 after READ_LAT cycles (1, and 2 in a second build).
- Double write: add0=add1=0x05, data0_in=0x11, data1_in=0x22, WR_PRIO=0 -> collision pulses 1 cycle; a later read gives 0x11. With WR_PRIO=1 the read gives 0x22.
- Read-during-write: mem[0x07]=0x33; port0 writes 0x44 to 0x07 while port1 reads 0x07 -> data1_out=0x33 (RDW_NEW=0) or 0x44 (RDW_NEW=1); collision=0.
- Enable/reset abort: en=0 during a READ_LAT=2 read -> data*_out=0 and valid*=0, and no stale valid appears later. rst asserted at sweep cycle 30 -> sweep restarts and init_busy lasts a further 64 cycles.
- Parity (DPRAM_PARITY_EN): write 0x01 then read it -> parity_err0=0. Force a flipped stored bit via backdoor -> parity_err0=1 aligned with valid0.

Source files
------------

// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types, constants and helpers for the dpram_mp memory.
//   sweep_state_t  : power-up clear sequencer states (CLEAR, RUN).
//   RDW_MODE_*     : encodings for the read-during-write parameter RDW_NEW.
//   even_parity()  : even-parity bit of a word, zero-extended to PAR_MAX_W.
package dpram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sweep_state_t;

    localparam int RDW_MODE_OLD = 0;  // cross-port read sees pre-write contents
    localparam int RDW_MODE_NEW = 1;  // cross-port read sees the data being written

    // Widest word the parity helper accepts. Callers zero-extend, and zero
    // padding does not change the parity.
    localparam int PAR_MAX_W = 256;

    // Bit that makes the total number of ones (data plus this bit) even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// dpram_rd_pipe: per-port read pipeline of LAT (1 or 2) registered stages.
//   clk, rst     : clock and synchronous active-high reset.
//   flush        : clears every stage to zero (global enable dropped).
//   rd_en        : a read was issued this cycle; rd_data is its payload.
//   q, q_valid   : registered payload and its fresh-data flag.
// Payload bits whose HOLD_MASK bit is 1 keep their last value between reads.
// Bits whose HOLD_MASK bit is 0 drop to 0. Status flags use the cleared bits,
// so they stay aligned with q_valid.
module dpram_rd_pipe #(
    parameter int             W         = 8,
    parameter int             LAT       = 1,
    parameter logic [W-1:0]   HOLD_MASK = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         rd_en,
    input  logic [W-1:0] rd_data,
    output logic [W-1:0] q,
    output logic         q_valid
);

    logic         st_en_s;
    logic [W-1:0] st_data_s;
    logic [W-1:0] q_r;
    logic         q_valid_r;

    generate
        if (LAT == 2) begin : g_lat2
            logic [W-1:0] a_data_r;
            logic         a_valid_r;

            // Extra stage: captures the raw read one cycle before the output stage.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    a_data_r  <= '0;
                    a_valid_r <= 1'b0;
                end else if (rd_en) begin
                    a_data_r  <= rd_data;
                    a_valid_r <= 1'b1;
                end else begin
                    a_valid_r <= 1'b0;
                end
            end

            assign st_en_s   = a_valid_r;
            assign st_data_s = a_data_r;
        end else begin : g_lat1
            assign st_en_s   = rd_en;
            assign st_data_s = rd_data;
        end
    endgenerate

    // Output stage: load on a fresh read, otherwise hold data and drop valid.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else if (st_en_s) begin
            q_r       <= st_data_s;
            q_valid_r <= 1'b1;
        end else begin
            q_r       <= q_r & HOLD_MASK;
            q_valid_r <= 1'b0;
        end
    end

    assign q       = q_r;
    assign q_valid = q_valid_r;

endmodule

// File: rtl/dpram_mp.sv
// dpram_mp: parametrised true dual-port RAM with a power-up clear sweep.
//   clk, rst              : single clock, synchronous active-high reset.
//   en                    : global enable; low in RUN flushes outputs, blocks access.
//   wr0/wr1               : port mode, 0 = write, 1 = read.
//   add0/add1             : port addresses.
//   data0_in/data1_in     : port write data.
//   data0_out/data1_out   : port read data (READ_LAT cycles after the read).
//   valid0/valid1         : read data on dataN_out is fresh this cycle.
//   collision             : pulse after both ports wrote the same address.
//   init_busy             : clear sweep running; ports ignored.
// Optional feature macro DPRAM_PARITY_EN: stores one even-parity bit per word
// and adds parity_err0/parity_err1, aligned with valid0/valid1.
module dpram_mp
    import dpram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int READ_LAT = 1,
    parameter int WR_PRIO  = 0,
    parameter int RDW_NEW  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] add0,
    input  logic [ADDR_W-1:0] add1,
    input  logic [DATA_W-1:0] data0_in,
    input  logic [DATA_W-1:0] data1_in,
    output logic [DATA_W-1:0] data0_out,
    output logic [DATA_W-1:0] data1_out,
    output logic              valid0,
    output logic              valid1,
    output logic              collision,
    output logic              init_busy
`ifdef DPRAM_PARITY_EN
    ,
    output logic              parity_err0,
    output logic              parity_err1
`endif
);

`ifdef DPRAM_PARITY_EN
    localparam int             MW        = DATA_W + 1;
    localparam logic [MW-1:0]  HOLD_MASK = {1'b0, {DATA_W{1'b1}}};
`else
    localparam int             MW        = DATA_W;
    localparam logic [MW-1:0]  HOLD_MASK = '1;
`endif

    logic [MW-1:0]     mem_r [DEPTH];

    sweep_state_t      state_r, state_nxt_s;
    logic [ADDR_W-1:0] clr_addr_r, clr_addr_nxt_s;
    logic              sweep_we_s;

    logic              act_s, flush_s;
    logic              we0_s, we1_s, re0_s, re1_s;
    logic              same_addr_s, dbl_wr_s, store0_s, store1_s;
    logic [MW-1:0]     wword0_s, wword1_s, rword0_s, rword1_s, pl0_s, pl1_s;
    logic [MW-1:0]     q0_s, q1_s;
    logic              collision_r;

    // Sweep sequencer next state: clear one word per cycle, then run forever.
    always_comb begin
        state_nxt_s    = state_r;
        clr_addr_nxt_s = clr_addr_r;
        sweep_we_s     = 1'b0;
        case (state_r)
            CLEAR: begin
                sweep_we_s = ~rst;
                if (clr_addr_r == ADDR_W'(DEPTH - 1)) begin
                    state_nxt_s = RUN;
                end else begin
                    clr_addr_nxt_s = clr_addr_r + ADDR_W'(1);
                end
            end
            RUN: begin
                state_nxt_s = RUN;
            end
            default: begin
                state_nxt_s = CLEAR;
            end
        endcase
    end

    // Sweep sequencer state register; reset restarts the sweep at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= CLEAR;
            clr_addr_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            clr_addr_r <= clr_addr_nxt_s;
        end
    end

    assign init_busy   = (state_r == CLEAR);
    assign act_s       = (state_r == RUN) & en & ~rst;
    assign flush_s     = (state_r == RUN) & ~en;
    assign we0_s       = act_s & ~wr0;
    assign we1_s       = act_s & ~wr1;
    assign re0_s       = act_s & wr0;
    assign re1_s       = act_s & wr1;
    assign same_addr_s = (add0 == add1);
    assign dbl_wr_s    = we0_s & we1_s & same_addr_s;
    // On a same-address double write only the priority port stores.
    assign store0_s    = we0_s & ~(dbl_wr_s & (WR_PRIO != 0));
    assign store1_s    = we1_s & ~(dbl_wr_s & (WR_PRIO == 0));

`ifdef DPRAM_PARITY_EN
    assign wword0_s = {even_parity(PAR_MAX_W'(data0_in)), data0_in};
    assign wword1_s = {even_parity(PAR_MAX_W'(data1_in)), data1_in};
`else
    assign wword0_s = data0_in;
    assign wword1_s = data1_in;
`endif

    // Port 0 read word, bypassing port 1's write data in write-through mode.
    always_comb begin
        rword0_s = mem_r[add0];
        if ((RDW_NEW == RDW_MODE_NEW) && we1_s && same_addr_s) begin
            rword0_s = wword1_s;
        end else begin
            rword0_s = mem_r[add0];
        end
    end

    // Port 1 read word, bypassing port 0's write data in write-through mode.
    always_comb begin
        rword1_s = mem_r[add1];
        if ((RDW_NEW == RDW_MODE_NEW) && we0_s && same_addr_s) begin
            rword1_s = wword0_s;
        end else begin
            rword1_s = mem_r[add1];
        end
    end

`ifdef DPRAM_PARITY_EN
    // The top payload bit carries the parity-check result, not the stored parity.
    assign pl0_s = {(rword0_s[DATA_W] != even_parity(PAR_MAX_W'(rword0_s[DATA_W-1:0]))),
                    rword0_s[DATA_W-1:0]};
    assign pl1_s = {(rword1_s[DATA_W] != even_parity(PAR_MAX_W'(rword1_s[DATA_W-1:0]))),
                    rword1_s[DATA_W-1:0]};
`else
    assign pl0_s = rword0_s;
    assign pl1_s = rword1_s;
`endif

    // Storage update: the sweep owns the array while clearing, the ports otherwise.
    always_ff @(posedge clk) begin
        if (sweep_we_s) begin
            mem_r[clr_addr_r] <= '0;
        end else begin
            if (store0_s) begin
                mem_r[add0] <= wword0_s;
            end
            if (store1_s) begin
                mem_r[add1] <= wword1_s;
            end
        end
    end

    // Collision flag: registered one-cycle pulse per same-address double write.
    always_ff @(posedge clk) begin
        if (rst) begin
            collision_r <= 1'b0;
        end else begin
            collision_r <= dbl_wr_s;
        end
    end

    assign collision = collision_r;

    dpram_rd_pipe #(.W(MW), .LAT(READ_LAT), .HOLD_MASK(HOLD_MASK)) u_pipe0 (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_s),
        .rd_en   (re0_s),
        .rd_data (pl0_s),
        .q       (q0_s),
        .q_valid (valid0)
    );

    dpram_rd_pipe #(.W(MW), .LAT(READ_LAT), .HOLD_MASK(HOLD_MASK)) u_pipe1 (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_s),
        .rd_en   (re1_s),
        .rd_data (pl1_s),
        .q       (q1_s),
        .q_valid (valid1)
    );

    assign data0_out = q0_s[DATA_W-1:0];
    assign data1_out = q1_s[DATA_W-1:0];
`ifdef DPRAM_PARITY_EN
    assign parity_err0 = q0_s[DATA_W];
    assign parity_err1 = q1_s[DATA_W];
`endif

endmodule
